registro_leds_pwm: RTL and testbench
====================================

// Module: registro_leds_pwm
// PURPOSE
//  Memory-mapped LED peripheral; parametrised successor of the single 32-bit LED register.
//  N_LEDS outputs with static, blink, PWM-dim and blink+PWM modes.
//  Atomic SET/CLR/TOGGLE writes and register read-back.
//  Sits on the CPU data-bus decoder beside the other peripherals; one write port, one combinational read port.
// PARAMETERS
//  N_LEDS      16   number of LED channels (1..32)
//  PWM_BITS    8    PWM counter/duty width (2..16)
//  PRESC_BITS  16   prescaler register width
//  BLINK_BITS  8    blink half-period register width
//  PRESC_RST   0    prescaler reset value
//  BLINK_RST   127  blink half-period reset value (counted in PWM periods)
// PORTS
//  clck_i      in   1         clock
//  rst_i       in   1         asynchronous reset, active-low
//  we_i        in   1         write strobe, sampled on posedge clck_i
//  addr_i      in   3         word index into register map
//  data_i      in   32        write data
//  data_o      out  32        read data, combinational from addr_i
//  leds_o      out  N_LEDS    LED drive, registered
// BEHAVIOUR
//  Register map (addr_i):
//   0 VALUE  rw  LED mask; bits [N_LEDS-1:0]
//   1 MODE   rw  [1:0]: 00 static, 01 blink, 10 pwm, 11 blink+pwm
//   2 DUTY   rw  [PWM_BITS-1:0]
//   3 BLINK  rw  half-period in PWM periods
//   4 PRESC  rw  prescaler value
//   5 SET    wo  VALUE |= data
//   6 CLR    wo  VALUE &= ~data
//   7 TOGL   wo  VALUE ^= data
//  Field rules:
//   - Write data is truncated to the field width.
//   - Reads are zero-extended. Addresses 5-7 read 0.
//  Reset (rst_i=0, async):
//   - VALUE=0, MODE=00, DUTY=all-ones, BLINK=BLINK_RST, PRESC=PRESC_RST.
//   - presc_cnt=0, pwm_cnt=0, blink_cnt=0, phase=1, leds_o=0.
//   - Reset mid-operation aborts everything immediately; no pending write survives.
//  Timebase:
//   - tick=1 when presc_cnt==PRESC; presc_cnt then returns to 0, else increments.
//   - PRESC=0 gives a tick every cycle.
//   - pwm_cnt increments on tick and wraps 2^PWM_BITS-1 -> 0; wrap=tick & pwm_cnt==max.
//   - On wrap: if blink_cnt==BLINK then blink_cnt=0 and phase toggles, else blink_cnt+1.
//  PWM gate:
//   - pwm_on = (DUTY==all-ones) | (pwm_cnt < DUTY).
//   - DUTY=0 is always off; all-ones is always on.
//  Output:
//   - leds_o <= VALUE_next & (MODE[0] ? {N{phase}} : '1) & (MODE[1] ? {N{pwm_on}} : '1).
//   - A write accepted at edge k is visible on leds_o at edge k (next-state path).
//     This is the same latency as the previous LED register.
//  Writes:
//   - A write to PRESC or MODE clears presc_cnt, pwm_cnt and blink_cnt and sets phase=1,
//     so the new mode starts with LEDs on.
//   - A write to DUTY/BLINK takes effect on the next compare; counters are not cleared.
//   - we_i=0: no state change except the timebase.
//   - Only one register can be written per cycle; there is no SET/CLR collision.
// STRUCTURE
//  leds_pkg:
//   - Address localparams (LED_VALUE..LED_TOGL).
//   - typedef enum logic[1:0] led_mode_t {STATIC, BLINK, PWM, BLINK_PWM}.
//  Sub-module led_pwm_timebase:
//   - Inputs: PRESC, DUTY, BLINK and a clear pulse.
//   - Contents: prescaler, pwm_cnt, blink_cnt, phase.
//   - Outputs: pwm_on, phase.
//  Top level: register file, read mux and output gating.
// TESTING  (bench uses N_LEDS=8, PWM_BITS=4, PRESC_RST=0, BLINK_RST=1)
//  1 Reset: hold rst_i=0 3 cycles -> leds_o=0, read MODE=0, DUTY=0xF, BLINK=1. Assert rst_i mid-blink -> leds_o=0 without waiting for a clock edge.
//  2 Static: write VALUE=0x1644 -> leds_o=0x44 at the write edge; read VALUE=0x44.
//  3 Atomic: VALUE=0x0F, then SET 0x30 -> 0x3F, CLR 0x03 -> 0x3C, TOGL 0xFF -> 0xC3. Reads of addr 5-7 return 0.
//  4 PWM: VALUE=0xFF, MODE=10, DUTY=4 -> each 16-cycle period has 4 cycles 0xFF and 12 cycles 0x00. DUTY=0 -> always 0x00; DUTY=0xF -> always 0xFF.
//  5 Prescaler: PRESC=2 with DUTY=4 -> PWM period is 48 cycles and 12 of them are high.
//  6 Blink: MODE=01, BLINK=1, VALUE=0xA5 -> 0xA5 for 32 cycles, then 0x00 for 32 cycles, repeating.
//    Writing MODE mid-off-phase restarts the pattern with leds_o=0xA5.

Source files
------------

// File: rtl/leds_pkg.sv
// Shared definitions for the LED PWM peripheral.
//   - Word addresses of the register map.
//   - LED mode encoding (bit 0 = blink gate, bit 1 = PWM gate).
package leds_pkg;

   localparam logic [2:0] LED_VALUE = 3'd0;
   localparam logic [2:0] LED_MODE  = 3'd1;
   localparam logic [2:0] LED_DUTY  = 3'd2;
   localparam logic [2:0] LED_BLINK = 3'd3;
   localparam logic [2:0] LED_PRESC = 3'd4;
   localparam logic [2:0] LED_SET   = 3'd5;
   localparam logic [2:0] LED_CLR   = 3'd6;
   localparam logic [2:0] LED_TOGL  = 3'd7;

   typedef enum logic [1:0] {
      STATIC    = 2'b00,
      BLINK     = 2'b01,
      PWM       = 2'b10,
      BLINK_PWM = 2'b11
   } led_mode_t;

endpackage

// File: rtl/led_pwm_timebase.sv
// Timebase for the LED peripheral: prescaler, PWM counter, blink counter and
// blink phase.
// Ports:
//   clck_i  in   clock
//   rst_i   in   async reset, active-low
//   clear   in   restart the timebase (counters to 0, phase on)
//   presc   in   prescaler terminal value
//   duty    in   PWM duty, already including a write in this cycle
//   blink   in   blink half-period in PWM periods
//   pwm_on  out  PWM gate for the state being loaded at this edge
//   phase   out  blink phase for the state being loaded at this edge
// Both outputs are taken from the next-state values so the top-level LED
// register lines up with the counters it is gated by.
module led_pwm_timebase #(
   parameter int PWM_BITS   = 8,
   parameter int PRESC_BITS = 16,
   parameter int BLINK_BITS = 8
) (
   input  logic                  clck_i,
   input  logic                  rst_i,
   input  logic                  clear,
   input  logic [PRESC_BITS-1:0] presc,
   input  logic [PWM_BITS-1:0]   duty,
   input  logic [BLINK_BITS-1:0] blink,
   output logic                  pwm_on,
   output logic                  phase
);

   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

   logic [PRESC_BITS-1:0] presc_cnt, presc_n;
   logic [PWM_BITS-1:0]   pwm_cnt,   pwm_n;
   logic [BLINK_BITS-1:0] blink_cnt, blink_n;
   logic                  phase_q,   phase_n;
   logic                  tick, wrap;

   always_comb begin
      presc_n = presc_cnt;
      pwm_n   = pwm_cnt;
      blink_n = blink_cnt;
      phase_n = phase_q;
      tick    = (presc_cnt == presc);
      wrap    = tick && (pwm_cnt == PWM_MAX);
      if (clear) begin
         presc_n = '0;
         pwm_n   = '0;
         blink_n = '0;
         phase_n = 1'b1;
      end else begin
         presc_n = tick ? '0 : presc_cnt + 1'b1;
         if (tick)
            pwm_n = pwm_cnt + 1'b1;
         if (wrap) begin
            if (blink_cnt == blink) begin
               blink_n = '0;
               phase_n = ~phase_q;
            end else begin
               blink_n = blink_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clck_i or negedge rst_i) begin
      if (!rst_i) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         phase_q   <= 1'b1;
      end else begin
         presc_cnt <= presc_n;
         pwm_cnt   <= pwm_n;
         blink_cnt <= blink_n;
         phase_q   <= phase_n;
      end
   end

   // All-ones duty must stay lit through the cnt==max slot.
   assign pwm_on = (duty == PWM_MAX) || (pwm_n < duty);
   assign phase  = phase_n;

endmodule

// File: rtl/registro_leds_pwm.sv
// Memory-mapped LED peripheral with static, blink, PWM and blink+PWM modes,
// atomic SET/CLR/TOGGLE writes and combinational read-back.
// Ports:
//   clck_i  in   clock
//   rst_i   in   async reset, active-low
//   we_i    in   write strobe
//   addr_i  in   register word index
//   data_i  in   write data
//   data_o  out  read data, combinational from addr_i
//   leds_o  out  registered LED drive
module registro_leds_pwm
   import leds_pkg::*;
#(
   parameter int N_LEDS     = 16,
   parameter int PWM_BITS   = 8,
   parameter int PRESC_BITS = 16,
   parameter int BLINK_BITS = 8,
   parameter int PRESC_RST  = 0,
   parameter int BLINK_RST  = 127
) (
   input  logic              clck_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [2:0]        addr_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   output logic [N_LEDS-1:0] leds_o
);

   logic [N_LEDS-1:0]     value_q, value_d;
   led_mode_t             mode_q,  mode_d;
   logic [PWM_BITS-1:0]   duty_q,  duty_d;
   logic [BLINK_BITS-1:0] blink_q, blink_d;
   logic [PRESC_BITS-1:0] presc_q, presc_d;
   logic [N_LEDS-1:0]     leds_d;
   logic [1:0]            mode_bits;
   logic                  tb_clear, pwm_on, phase;
   logic                  unused_data;

   // Upper write-data bits are intentionally dropped by field truncation.
   assign unused_data = ^data_i;

   always_comb begin
      value_d = value_q;
      mode_d  = mode_q;
      duty_d  = duty_q;
      blink_d = blink_q;
      presc_d = presc_q;
      if (we_i) begin
         case (addr_i)
            LED_VALUE: value_d = data_i[N_LEDS-1:0];
            LED_MODE:  mode_d  = led_mode_t'(data_i[1:0]);
            LED_DUTY:  duty_d  = data_i[PWM_BITS-1:0];
            LED_BLINK: blink_d = data_i[BLINK_BITS-1:0];
            LED_PRESC: presc_d = data_i[PRESC_BITS-1:0];
            LED_SET:   value_d = value_q | data_i[N_LEDS-1:0];
            LED_CLR:   value_d = value_q & ~data_i[N_LEDS-1:0];
            default:   value_d = value_q ^ data_i[N_LEDS-1:0];
         endcase
      end
   end

   // A new mode or prescaler restarts the timebase so the pattern begins lit.
   assign tb_clear = we_i && ((addr_i == LED_MODE) || (addr_i == LED_PRESC));

   always_ff @(posedge clck_i or negedge rst_i) begin
      if (!rst_i) begin
         value_q <= '0;
         mode_q  <= STATIC;
         duty_q  <= '1;
         blink_q <= BLINK_BITS'(BLINK_RST);
         presc_q <= PRESC_BITS'(PRESC_RST);
      end else begin
         value_q <= value_d;
         mode_q  <= mode_d;
         duty_q  <= duty_d;
         blink_q <= blink_d;
         presc_q <= presc_d;
      end
   end

   led_pwm_timebase #(
      .PWM_BITS   (PWM_BITS),
      .PRESC_BITS (PRESC_BITS),
      .BLINK_BITS (BLINK_BITS)
   ) u_timebase (
      .clck_i (clck_i),
      .rst_i  (rst_i),
      .clear  (tb_clear),
      .presc  (presc_q),
      .duty   (duty_d),
      .blink  (blink_q),
      .pwm_on (pwm_on),
      .phase  (phase)
   );

   // Gating uses next-state values so a write lands on leds_o at its own edge.
   always_comb begin
      mode_bits = mode_d;
      leds_d    = value_d;
      if (mode_bits[0])
         leds_d = leds_d & {N_LEDS{phase}};
      if (mode_bits[1])
         leds_d = leds_d & {N_LEDS{pwm_on}};
   end

   always_ff @(posedge clck_i or negedge rst_i) begin
      if (!rst_i)
         leds_o <= '0;
      else
         leds_o <= leds_d;
   end

   always_comb begin
      data_o = '0;
      case (addr_i)
         LED_VALUE: data_o[N_LEDS-1:0]     = value_q;
         LED_MODE:  data_o[1:0]            = mode_q;
         LED_DUTY:  data_o[PWM_BITS-1:0]   = duty_q;
         LED_BLINK: data_o[BLINK_BITS-1:0] = blink_q;
         LED_PRESC: data_o[PRESC_BITS-1:0] = presc_q;
         default:   data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_registro_leds_pwm.sv
module tb_registro_leds_pwm;

   logic        clck_i = 1'b0;
   logic        rst_i  = 1'b0;
   logic        we_i   = 1'b0;
   logic [2:0]  addr_i = 3'd0;
   logic [31:0] data_i = 32'd0;
   logic [31:0] data_o;
   logic [7:0]  leds_o;

   int n_vec = 0;
   int n_bad = 0;

   registro_leds_pwm #(
      .N_LEDS     (8),
      .PWM_BITS   (4),
      .PRESC_BITS (16),
      .BLINK_BITS (8),
      .PRESC_RST  (0),
      .BLINK_RST  (1)
   ) dut (
      .clck_i (clck_i),
      .rst_i  (rst_i),
      .we_i   (we_i),
      .addr_i (addr_i),
      .data_i (data_i),
      .data_o (data_o),
      .leds_o (leds_o)
   );

   always #5 clck_i = ~clck_i;

   // Returns 1 ns after the write edge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clck_i);
      we_i   = 1'b1;
      addr_i = a;
      data_i = d;
      @(posedge clck_i);
      #1;
      we_i   = 1'b0;
      data_i = 32'd0;
   endtask

   task automatic step();
      @(posedge clck_i);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] exp_rd [5];
      exp_rd = '{32'h0, 32'h0, 32'hF, 32'h1, 32'h0};
      // a write held during reset must not land
      @(negedge clck_i);
      rst_i = 1'b0; we_i = 1'b1; addr_i = 3'd0; data_i = 32'hFF;
      repeat (3) @(posedge clck_i);
      #1;
      n_vec++;
      if (leds_o !== 8'h00) begin
         n_bad++; $display("FAIL reset_leds: got %h want 00", leds_o);
      end
      @(negedge clck_i);
      we_i = 1'b0; data_i = 32'd0; rst_i = 1'b1;
      for (int a = 0; a < 5; a++) begin
         addr_i = 3'(a);
         #1;
         n_vec++;
         if (data_o !== exp_rd[a]) begin
            n_bad++; $display("FAIL reset_read[%0d]: got %h want %h", a, data_o, exp_rd[a]);
         end
      end
      // async reset in the middle of a blink pattern
      wr(3'd0, 32'hA5);
      wr(3'd1, 32'h1);
      step(); step(); step();
      n_vec++;
      if (leds_o !== 8'hA5) begin
         n_bad++; $display("FAIL blink_pre_reset: got %h want a5", leds_o);
      end
      #2;
      rst_i = 1'b0;
      #1;
      n_vec++;
      if (leds_o !== 8'h00) begin
         n_bad++; $display("FAIL async_reset_leds: got %h want 00", leds_o);
      end
      addr_i = 3'd1;
      #1;
      n_vec++;
      if (data_o !== 32'h0) begin
         n_bad++; $display("FAIL async_reset_mode: got %h want 0", data_o);
      end
      @(negedge clck_i);
      rst_i = 1'b1;
   endtask

   task automatic test_static();
      wr(3'd0, 32'h1644);
      n_vec++;
      if (leds_o !== 8'h44) begin
         n_bad++; $display("FAIL static_leds: got %h want 44", leds_o);
      end
      addr_i = 3'd0;
      #1;
      n_vec++;
      if (data_o !== 32'h44) begin
         n_bad++; $display("FAIL static_read: got %h want 44", data_o);
      end
   endtask

   task automatic test_atomic();
      logic [2:0] a_tab [4];
      logic [7:0] d_tab [4];
      logic [7:0] e_tab [4];
      a_tab = '{3'd0, 3'd5, 3'd6, 3'd7};
      d_tab = '{8'h0F, 8'h30, 8'h03, 8'hFF};
      e_tab = '{8'h0F, 8'h3F, 8'h3C, 8'hC3};
      for (int i = 0; i < 4; i++) begin
         wr(a_tab[i], {24'h0, d_tab[i]});
         n_vec++;
         if (leds_o !== e_tab[i]) begin
            n_bad++; $display("FAIL atomic[%0d]: got %h want %h", i, leds_o, e_tab[i]);
         end
      end
      addr_i = 3'd0;
      #1;
      n_vec++;
      if (data_o !== 32'hC3) begin
         n_bad++; $display("FAIL atomic_read: got %h want c3", data_o);
      end
      for (int a = 5; a < 8; a++) begin
         addr_i = 3'(a);
         #1;
         n_vec++;
         if (data_o !== 32'h0) begin
            n_bad++; $display("FAIL wo_read[%0d]: got %h want 0", a, data_o);
         end
      end
   endtask

   task automatic test_pwm();
      logic [7:0] exp;
      wr(3'd0, 32'hFF);
      wr(3'd2, 32'h14);
      addr_i = 3'd2;
      #1;
      n_vec++;
      if (data_o !== 32'h4) begin
         n_bad++; $display("FAIL duty_trunc: got %h want 4", data_o);
      end
      wr(3'd1, 32'h2);
      for (int i = 0; i < 48; i++) begin
         exp = ((i % 16) < 4) ? 8'hFF : 8'h00;
         n_vec++;
         if (leds_o !== exp) begin
            n_bad++; $display("FAIL pwm4[%0d]: got %h want %h", i, leds_o, exp);
         end
         step();
      end
      wr(3'd2, 32'h0);
      for (int i = 0; i < 32; i++) begin
         n_vec++;
         if (leds_o !== 8'h00) begin
            n_bad++; $display("FAIL pwm0[%0d]: got %h want 00", i, leds_o);
         end
         step();
      end
      wr(3'd2, 32'hF);
      for (int i = 0; i < 32; i++) begin
         n_vec++;
         if (leds_o !== 8'hFF) begin
            n_bad++; $display("FAIL pwmF[%0d]: got %h want ff", i, leds_o);
         end
         step();
      end
   endtask

   task automatic test_presc();
      logic [7:0] exp;
      wr(3'd2, 32'h4);
      wr(3'd4, 32'h2);
      for (int i = 0; i < 96; i++) begin
         exp = (((i / 3) % 16) < 4) ? 8'hFF : 8'h00;
         n_vec++;
         if (leds_o !== exp) begin
            n_bad++; $display("FAIL presc[%0d]: got %h want %h", i, leds_o, exp);
         end
         step();
      end
      addr_i = 3'd4;
      #1;
      n_vec++;
      if (data_o !== 32'h2) begin
         n_bad++; $display("FAIL presc_read: got %h want 2", data_o);
      end
   endtask

   task automatic test_blink();
      logic [7:0] exp;
      wr(3'd0, 32'hA5);
      wr(3'd3, 32'h1);
      wr(3'd4, 32'h0);
      wr(3'd1, 32'h1);
      for (int i = 0; i < 45; i++) begin
         exp = (((i / 32) % 2) == 0) ? 8'hA5 : 8'h00;
         n_vec++;
         if (leds_o !== exp) begin
            n_bad++; $display("FAIL blink[%0d]: got %h want %h", i, leds_o, exp);
         end
         step();
      end
      // rewrite MODE during the off half: pattern restarts lit
      wr(3'd1, 32'h1);
      for (int i = 0; i < 96; i++) begin
         exp = (((i / 32) % 2) == 0) ? 8'hA5 : 8'h00;
         n_vec++;
         if (leds_o !== exp) begin
            n_bad++; $display("FAIL blink_restart[%0d]: got %h want %h", i, leds_o, exp);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_atomic();
      test_pwm();
      test_presc();
      test_blink();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
